// File: rtl/sram_ctrl_pkg.sv
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared types and default geometry for the SRAM port initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

    localparam int c_DATA_WIDTH = 32;
    localparam int c_ADDR_WIDTH = 9;
    localparam int c_NUM_WMASKS = 4;

    typedef enum logic [0:0] {
        c_SCRUB = 1'b0,
        c_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic                    we;
        logic [c_ADDR_WIDTH-1:0] addr;
        logic [c_DATA_WIDTH-1:0] wdata;
        logic [c_NUM_WMASKS-1:0] wmask;
    } req_t;

endpackage

`default_nettype wire

// File: rtl/sram_rsp_fifo.sv
// ============================================================================
// Module      : sram_rsp_fifo
// Description : Synchronous DEPTH x WIDTH response FIFO with push/pop/count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage carries no reset; only pointers and occupancy define contents.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && w_full && !w_do_pop));

endmodule

`default_nettype wire

// File: rtl/sram_port0_initiator.sv
// ============================================================================
// Module      : sram_port0_initiator
// Description : Valid/ready initiator for port 0 (1RW) of the OpenRAM 32x512
//               macro; optional power-on zero scrub via SRAM_INIT_SCRUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port0_initiator
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int NUM_WMASKS = c_NUM_WMASKS,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int c_CW = $clog2(RSP_DEPTH + 1);
    localparam logic [c_CW-1:0] c_MAX_CREDIT = c_CW'(RSP_DEPTH);

    req_t                  w_req;
    logic                  w_acc;
    logic                  w_acc_rd;
    logic                  w_pop;
    logic                  w_scrub;
    logic [ADDR_WIDTH-1:0] w_scrub_addr;
    logic                  w_fifo_empty;
    logic [c_CW-1:0]       w_fifo_count;
    logic [c_CW-1:0]       r_credit;
    logic [1:0]            r_rd_trk;

    assign w_req = '{we: req_we, addr: req_addr, wdata: req_wdata, wmask: req_wmask};

    // Writes are also gated by credit so request order never needs tracking.
    assign req_ready = !busy && (r_credit < c_MAX_CREDIT);
    assign w_acc     = req_valid && req_ready;
    assign w_acc_rd  = w_acc && !w_req.we;
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_valid = !w_fifo_empty;
    assign busy      = w_scrub;

`ifdef SRAM_INIT_SCRUB_EN
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_scrub_addr;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state      <= c_SCRUB;
            r_scrub_addr <= '0;
        end else if (r_state == c_SCRUB) begin
            r_scrub_addr <= r_scrub_addr + 1'b1;
            if (r_scrub_addr == c_LAST_ADDR) begin
                r_state <= c_RUN;
            end
        end
    end

    assign w_scrub      = (r_state == c_SCRUB);
    assign w_scrub_addr = r_scrub_addr;
`else
    assign w_scrub      = 1'b0;
    assign w_scrub_addr = '0;
`endif

    // Macro inputs are registered so they are stable across the macro's own capture edge.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
        end else if (w_scrub) begin
            csb0   <= 1'b0;
            web0   <= 1'b0;
            wmask0 <= '1;
            addr0  <= w_scrub_addr;
            din0   <= '0;
        end else if (w_acc) begin
            csb0   <= 1'b0;
            web0   <= ~w_req.we;
            wmask0 <= w_req.we ? w_req.wmask : '0;
            addr0  <= w_req.addr;
            din0   <= w_req.wdata;
        end else begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
        end
    end

    // Stage 1: macro latches the read; stage 2: dout0 is valid at this edge.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_rd_trk <= '0;
            r_credit <= '0;
        end else begin
            r_rd_trk <= {r_rd_trk[0], w_acc_rd};
            case ({w_acc_rd, w_pop})
                2'b10:   r_credit <= r_credit + 1'b1;
                2'b01:   r_credit <= r_credit - 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk     (clk0),
        .rst     (rst0),
        .i_push  (r_rd_trk[1]),
        .i_wdata (dout0),
        .i_pop   (w_pop),
        .o_rdata (rsp_rdata),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    a_credit_covers_fifo: assert property (@(posedge clk0) disable iff (rst0)
        r_credit >= w_fifo_count);

endmodule

`default_nettype wire
